duck_sprite_fetch: RTL and testbench

DUCK_SPRITE_FETCH -- requirements
Module: duck_sprite_fetch

---
 rtl/duck_pkg.sv | 10 +
 rtl/duck_anim_ctr.sv | 31 +++
 rtl/duck_sprite_fetch.sv | 123 ++++++++++++
 tb/tb_duck_sprite_fetch.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/duck_pkg.sv
// rtl/duck_pkg.sv - shared sprite geometry and datapath widths for the duck sprite fetcher
package duck_pkg;
  localparam int SPRITE_W   = 20;
  localparam int SPRITE_H   = 20;
  localparam int NUM_FRAMES = 3;
  localparam int ADDR_W     = 19;
  localparam int IDX_W      = 3;
  localparam int COORD_W    = 10;
  localparam int FRAME_W    = 2;
endpackage

// File: rtl/duck_anim_ctr.sv
// rtl/duck_anim_ctr.sv - animation divider and frame counter, advanced on frame_start
module duck_anim_ctr #(
  parameter int NUM_FRAMES = duck_pkg::NUM_FRAMES,
  parameter int ANIM_DIV   = 8
) (
  input  logic                         Clk,
  input  logic                         Reset_n,
  input  logic                         frame_start,
  input  logic                         anim_en,
  output logic [duck_pkg::FRAME_W-1:0] cur_frame
);
  import duck_pkg::*;

  localparam int DIV_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

  logic [DIV_W-1:0] div_q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      div_q     <= '0;
      cur_frame <= '0;
    end else if (frame_start && anim_en) begin
      if (div_q == DIV_W'(ANIM_DIV - 1)) begin
        div_q     <= '0;
        cur_frame <= (cur_frame == FRAME_W'(NUM_FRAMES - 1)) ? '0 : cur_frame + 1'b1;
      end else begin
        div_q <= div_q + 1'b1;
      end
    end
  end
endmodule

// File: rtl/duck_sprite_fetch.sv
// rtl/duck_sprite_fetch.sv - 3-stage sprite hit test, RAM address and palette pipeline
// Optional horizontal mirroring via `define DUCK_SPRITE_HFLIP_EN (adds the flip input).
module duck_sprite_fetch #(
  parameter int SPRITE_W   = duck_pkg::SPRITE_W,
  parameter int SPRITE_H   = duck_pkg::SPRITE_H,
  parameter int NUM_FRAMES = duck_pkg::NUM_FRAMES,
  parameter int ANIM_DIV   = 8
) (
  input  logic                         Clk,
  input  logic                         Reset_n,
  input  logic                         frame_start,
  input  logic                         pix_valid,
  input  logic [duck_pkg::COORD_W-1:0] DrawX,
  input  logic [duck_pkg::COORD_W-1:0] DrawY,
  input  logic [duck_pkg::COORD_W-1:0] sprite_x,
  input  logic [duck_pkg::COORD_W-1:0] sprite_y,
  input  logic                         sprite_en,
  input  logic                         anim_en,
`ifdef DUCK_SPRITE_HFLIP_EN
  input  logic                         flip,
`endif
  input  logic [4:0]                   ram_data,
  output logic [duck_pkg::ADDR_W-1:0]  read_address,
  output logic                         out_valid,
  output logic                         out_hit,
  output logic [duck_pkg::IDX_W-1:0]   out_index,
  output logic [duck_pkg::FRAME_W-1:0] cur_frame
);
  import duck_pkg::*;

  localparam int FRAME_SIZE = SPRITE_W * SPRITE_H;

  logic [COORD_W-1:0] sx_q, sy_q;
  logic               en_q;
  logic               flip_q;

  // Shadow copies update on the frame_start edge, so the coinciding pixel still sees old values.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sx_q <= '0;
      sy_q <= '0;
      en_q <= 1'b0;
    end else if (frame_start) begin
      sx_q <= sprite_x;
      sy_q <= sprite_y;
      en_q <= sprite_en;
    end
  end

`ifdef DUCK_SPRITE_HFLIP_EN
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)
      flip_q <= 1'b0;
    else if (frame_start)
      flip_q <= flip;
  end
`else
  assign flip_q = 1'b0;
`endif

  duck_anim_ctr #(
    .NUM_FRAMES (NUM_FRAMES),
    .ANIM_DIV   (ANIM_DIV)
  ) u_anim (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .frame_start (frame_start),
    .anim_en     (anim_en),
    .cur_frame   (cur_frame)
  );

  // 11-bit compares keep sx+SPRITE_W from wrapping back onto the left screen edge.
  logic [COORD_W:0] x11, y11, sx11, sy11;
  logic             in_x, in_y, hit1;

  assign x11  = {1'b0, DrawX};
  assign y11  = {1'b0, DrawY};
  assign sx11 = {1'b0, sx_q};
  assign sy11 = {1'b0, sy_q};
  assign in_x = (x11 >= sx11) && (x11 < sx11 + (COORD_W+1)'(SPRITE_W));
  assign in_y = (y11 >= sy11) && (y11 < sy11 + (COORD_W+1)'(SPRITE_H));
  assign hit1 = pix_valid & en_q & in_x & in_y;

  logic [ADDR_W-1:0] row, col_raw, col, base, offset, next_addr;

  assign row       = ADDR_W'(DrawY - sy_q);
  assign col_raw   = ADDR_W'(DrawX - sx_q);
  assign col       = flip_q ? (ADDR_W'(SPRITE_W - 1) - col_raw) : col_raw;
  assign base      = ADDR_W'(FRAME_SIZE * int'(cur_frame));
  assign offset    = row * ADDR_W'(SPRITE_W) + col;
  assign next_addr = hit1 ? (base + offset) : base;

  logic             v1_q, h1_q, v2_q, h2_q;
  logic [IDX_W-1:0] pix_idx;
  logic             opaque;
  logic             unused_ram_bits;

  assign pix_idx         = ram_data[IDX_W-1:0];
  assign opaque          = h2_q && (pix_idx != '0);
  assign unused_ram_bits = ^ram_data[4:3];

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      read_address <= '0;
      v1_q         <= 1'b0;
      h1_q         <= 1'b0;
      v2_q         <= 1'b0;
      h2_q         <= 1'b0;
      out_valid    <= 1'b0;
      out_hit      <= 1'b0;
      out_index    <= '0;
    end else begin
      read_address <= next_addr;
      v1_q         <= pix_valid;
      h1_q         <= hit1;
      v2_q         <= v1_q;
      h2_q         <= h1_q;
      out_valid    <= v2_q;
      out_hit      <= opaque;
      out_index    <= opaque ? pix_idx : '0;
    end
  end
endmodule

// File: tb/tb_duck_sprite_fetch.sv
// tb/tb_duck_sprite_fetch.sv - randomized self-checking bench for duck_sprite_fetch
module tb_duck_sprite_fetch;
  localparam int W    = 20;
  localparam int H    = 20;
  localparam int NF   = 3;
  localparam int AD   = 8;
  localparam int MAXN = 8192;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        frame_start = 1'b0;
  logic        pix_valid = 1'b0;
  logic [9:0]  DrawX = '0, DrawY = '0, sprite_x = '0, sprite_y = '0;
  logic        sprite_en = 1'b0, anim_en = 1'b0;
  logic        flip = 1'b0;
  logic [4:0]  ram_data = '0;
  logic [18:0] read_address;
  logic        out_valid, out_hit;
  logic [2:0]  out_index;
  logic [1:0]  cur_frame;

  always #5 Clk = ~Clk;

  duck_sprite_fetch dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .frame_start  (frame_start),
    .pix_valid    (pix_valid),
    .DrawX        (DrawX),
    .DrawY        (DrawY),
    .sprite_x     (sprite_x),
    .sprite_y     (sprite_y),
    .sprite_en    (sprite_en),
    .anim_en      (anim_en),
`ifdef DUCK_SPRITE_HFLIP_EN
    .flip         (flip),
`endif
    .ram_data     (ram_data),
    .read_address (read_address),
    .out_valid    (out_valid),
    .out_hit      (out_hit),
    .out_index    (out_index),
    .cur_frame    (cur_frame)
  );

  logic [4:0] mem [0:2047];
  always @(posedge Clk)
    ram_data <= (read_address < 19'd2048) ? mem[read_address[10:0]] : 5'd0;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Reference state: what the sprite engine should believe after each frame_start.
  int sx_m, sy_m, fs_cnt, n, base_n;
  bit en_m, fl_m;
  int e_addr [0:MAXN-1];
  int e_v    [0:MAXN-1];
  int e_h    [0:MAXN-1];
  int e_i    [0:MAXN-1];

  function automatic int model_frame();
    return (fs_cnt / AD) % NF;
  endfunction

  task automatic step(input bit fs, input bit pv, input int x, input int y,
                      input int spx, input int spy, input bit sen, input bit aen, input bit fl);
    int col, addr, idx;
    bit hit;
    logic [4:0] m;
    @(negedge Clk);
    if (n - 1 >= base_n) check("read_address", int'(read_address), e_addr[n-1]);
    if (n - 3 >= base_n) begin
      check("out_valid", int'(out_valid), e_v[n-3]);
      check("out_hit",   int'(out_hit),   e_h[n-3]);
      check("out_index", int'(out_index), e_i[n-3]);
    end
    check("cur_frame", int'(cur_frame), model_frame());
    frame_start = fs;
    pix_valid   = pv;
    DrawX       = 10'(x);
    DrawY       = 10'(y);
    sprite_x    = 10'(spx);
    sprite_y    = 10'(spy);
    sprite_en   = sen;
    anim_en     = aen;
    flip        = fl;
    hit = pv && en_m && x >= sx_m && x < sx_m + W && y >= sy_m && y < sy_m + H;
    col = fl_m ? (W - 1 - (x - sx_m)) : (x - sx_m);
    addr = model_frame() * W * H;
    if (hit) addr = addr + (y - sy_m) * W + col;
    m = mem[addr];
    idx = int'(m[2:0]);
    e_addr[n] = addr;
    e_v[n]    = int'(pv);
    e_h[n]    = (hit && idx != 0) ? 1 : 0;
    e_i[n]    = (hit && idx != 0) ? idx : 0;
    if (fs) begin
      sx_m = spx;
      sy_m = spy;
      en_m = sen;
`ifdef DUCK_SPRITE_HFLIP_EN
      fl_m = fl;
`else
      fl_m = 1'b0;
`endif
      if (aen) fs_cnt++;
    end
    n++;
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset_n = 1'b0;
    #2;
    check("rst_read_address", int'(read_address), 0);
    check("rst_out_valid",    int'(out_valid), 0);
    check("rst_out_hit",      int'(out_hit), 0);
    check("rst_out_index",    int'(out_index), 0);
    check("rst_cur_frame",    int'(cur_frame), 0);
    frame_start = 1'b0;
    pix_valid   = 1'b0;
    @(negedge Clk);
    Reset_n = 1'b1;
    sx_m = 0; sy_m = 0; en_m = 1'b0; fl_m = 1'b0; fs_cnt = 0;
    base_n = n;
  endtask

  function automatic int near(input int c, input int span);
    int v;
    v = c + int'($urandom_range(0, span + 3)) - 2;
    return ((v % 1024) + 1024) % 1024;
  endfunction

  initial begin
    int x, y, spx, spy;
    n = 0; base_n = 0;
    for (int i = 0; i < 2048; i++) mem[i] = 5'($urandom);
    for (int i = 0; i < 2048; i += 3) mem[i] = 5'b11000;
    mem[5] = 5'b11011;
    mem[7] = 5'b10000;

    do_reset();
    step(0, 1, 100, 50, 100, 50, 1, 0, 0);
    step(1, 1, 100, 50, 100, 50, 1, 0, 0);
    step(0, 1, 100, 50, 100, 50, 1, 0, 0);
    step(0, 1, 119, 69, 100, 50, 1, 0, 0);
    step(0, 1,  99, 60, 100, 50, 1, 0, 0);
    step(0, 1, 120, 60, 100, 50, 1, 0, 0);
    step(0, 1, 105, 50, 100, 50, 1, 0, 0);
    step(0, 1, 107, 50, 100, 50, 1, 0, 0);
    step(0, 0, 105, 50, 100, 50, 1, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 100 + i, 55, 200, 50, 1, 0, 0);
    step(1, 0, 0, 0, 200, 50, 1, 0, 0);
    step(0, 1, 100, 55, 200, 50, 1, 0, 0);
    step(0, 1, 200, 55, 1015, 50, 1, 0, 0);
    step(1, 0, 0, 0, 1015, 50, 1, 0, 0);
    for (int i = 0; i < 20; i++) step(0, 1, i, 55, 1015, 50, 1, 0, 0);
    for (int i = 1015; i < 1024; i++) step(0, 1, i, 55, 1015, 50, 1, 0, 0);
    for (int i = 0; i < 26; i++) step(1, 1, 100, 50, 100, 50, 1, 1, 0);
    step(1, 1, 100, 50, 100, 50, 1, 0, 1);
    step(0, 1, 100, 50, 100, 50, 1, 0, 1);
    step(0, 1, 119, 50, 100, 50, 1, 0, 1);
    step(0, 1, 105, 69, 100, 50, 1, 0, 0);
    do_reset();
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 0, 1, 0, 0);

    for (int i = 0; i < 3000; i++) begin
      spx = ($urandom % 4 == 0) ? 1015 : int'($urandom % 1024);
      spy = ($urandom % 4 == 0) ? 1015 : int'($urandom % 1024);
      x = ($urandom % 4 != 0) ? near(sx_m, W) : int'($urandom % 1024);
      y = ($urandom % 4 != 0) ? near(sy_m, H) : int'($urandom % 1024);
      step(($urandom % 6) == 0, ($urandom % 4) != 0, x, y, spx, spy,
           ($urandom % 8) != 0, ($urandom % 4) != 0, 1'($urandom));
    end
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
